// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter interface.
// Bundles requester payloads, control and the registered broadcast.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int RSNUM_W = 3
);
    logic                        flush;
    logic                        cdb_stall;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*TAG_W-1:0]    req_tag;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ*RSNUM_W-1:0]  req_rsnum;
    logic [NUM_REQ-1:0]          ack;
    logic [RSNUM_W-1:0]          ack_rsnum;
    logic                        cdb_valid;
    logic [TAG_W-1:0]            cdb_tag;
    logic [DATA_W-1:0]           cdb_data;
    logic [1:0]                  cdb_src;

    modport master (
        output flush, cdb_stall,
        output req_valid, req_tag, req_data, req_rsnum,
        input  ack, ack_rsnum,
        input  cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  flush, cdb_stall,
        input  req_valid, req_tag, req_data, req_rsnum,
        output ack, ack_rsnum,
        output cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter.
// Picks one ready unit per cycle, registers the broadcast and the ack.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int RSNUM_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LG_W-1:0] LAST = LG_W'(NUM_REQ - 1);

    logic [LG_W-1:0]    last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [RSNUM_W-1:0] ack_rsnum_q, ack_rsnum_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [1:0]         cdb_src_q, cdb_src_d;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    int                 gidx;
    int                 idx;

    // Eligibility: valid, non-free tag, and not the unit being acked now.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] & ~ack_q[i]
                        & (bus.req_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        gidx  = 0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    // Next broadcast/ack state; idle unless a grant is taken.
    always_comb begin
        last_grant_d = last_grant_q;
        ack_d        = '0;
        ack_rsnum_d  = '0;
        cdb_valid_d  = 1'b0;
        cdb_tag_d    = '0;
        cdb_data_d   = '0;
        cdb_src_d    = '0;
        if (bus.flush) begin
            last_grant_d = LAST;
        end else if (found && !bus.cdb_stall) begin
            last_grant_d = LG_W'(gidx);
            ack_d[gidx]  = 1'b1;
            ack_rsnum_d  = bus.req_rsnum[gidx*RSNUM_W +: RSNUM_W];
            cdb_valid_d  = 1'b1;
            cdb_tag_d    = bus.req_tag[gidx*TAG_W +: TAG_W];
            cdb_data_d   = bus.req_data[gidx*DATA_W +: DATA_W];
            cdb_src_d    = 2'(gidx);
        end
    end

    // State registers; reset wins over flush and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= LAST;
            ack_q        <= '0;
            ack_rsnum_q  <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_src_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            ack_rsnum_q  <= ack_rsnum_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.ack_rsnum = ack_rsnum_q;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for the CDB arbiter.
// Hand-computed expectations checked with immediate assertions.
module tb_cdb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   tag0_seen;
    int   bad_bcast;

    cdb_arbiter_if #(.NUM_REQ(3), .TAG_W(4), .DATA_W(32), .RSNUM_W(3)) bus ();

    cdb_arbiter #(
        .NUM_REQ(3), .TAG_W(4), .DATA_W(32), .RSNUM_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: tag-0 requests and any valid broadcast of tag 0.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && bus.req_valid[i] && bus.req_tag[i*4 +: 4] == 4'd0) begin
                tag0_seen++;
                $display("protocol: unit %0d requests with free tag 0", i);
            end
        end
        if (bus.cdb_valid && bus.cdb_tag == 4'd0) bad_bcast++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic v, logic [3:0] t,
                           logic [31:0] d, logic [2:0] r);
        bus.req_valid[i]         = v;
        bus.req_tag[i*4 +: 4]    = t;
        bus.req_data[i*32 +: 32] = d;
        bus.req_rsnum[i*3 +: 3]  = r;
    endtask

    task automatic expect_out(string name, logic v, logic [3:0] t,
                              logic [31:0] d, logic [1:0] s,
                              logic [2:0] a, logic [2:0] r);
        logic [44:0] obs;
        logic [44:0] exp;
        obs = {bus.cdb_valid, bus.cdb_tag, bus.cdb_data,
               bus.cdb_src, bus.ack, bus.ack_rsnum};
        exp = {v, t, d, s, a, r};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic expect_idle(string name);
        expect_out(name, 1'b0, 4'd0, 32'd0, 2'd0, 3'b000, 3'd0);
    endtask

    task automatic expect_cnt(string name, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        tag0_seen = 0;
        bad_bcast = 0;
        rst = 1'b1;
        bus.flush     = 1'b0;
        bus.cdb_stall = 1'b0;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        bus.req_rsnum = '0;
        tick();
        tick();
        expect_idle("reset");
        rst = 1'b0;

        // single request from unit 0
        set_req(0, 1, 4'd5, 32'h1234, 3'd2);
        tick();
        expect_out("single", 1, 4'd5, 32'h1234, 2'd0, 3'b001, 3'd2);
        tick();
        expect_idle("single_masked");
        set_req(0, 0, 0, 0, 0);

        // all three continuously valid from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1, 4'd1, 32'hA0, 3'd1);
        set_req(1, 1, 4'd2, 32'hA1, 3'd2);
        set_req(2, 1, 4'd3, 32'hA2, 3'd3);
        for (int n = 0; n < 6; n++) begin
            tick();
            case (n % 3)
                0: expect_out("rr_u0", 1, 4'd1, 32'hA0, 2'd0, 3'b001, 3'd1);
                1: expect_out("rr_u1", 1, 4'd2, 32'hA1, 2'd1, 3'b010, 3'd2);
                default:
                   expect_out("rr_u2", 1, 4'd3, 32'hA2, 2'd2, 3'b100, 3'd3);
            endcase
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        set_req(2, 0, 0, 0, 0);
        tick();
        expect_idle("rr_drain");

        // unit 1 alone, new entry after each ack
        set_req(1, 1, 4'd6, 32'h66, 3'd4);
        tick();
        expect_out("b2b_t6", 1, 4'd6, 32'h66, 2'd1, 3'b010, 3'd4);
        tick();
        expect_idle("b2b_gap1");
        set_req(1, 1, 4'd7, 32'h77, 3'd5);
        tick();
        expect_out("b2b_t7", 1, 4'd7, 32'h77, 2'd1, 3'b010, 3'd5);
        tick();
        expect_idle("b2b_gap2");
        set_req(1, 1, 4'd8, 32'h88, 3'd6);
        tick();
        expect_out("b2b_t8", 1, 4'd8, 32'h88, 2'd1, 3'b010, 3'd6);
        tick();
        expect_idle("b2b_gap3");
        set_req(1, 0, 0, 0, 0);

        // stall with unit 2 (and unit 0) waiting; pointer stays at 1
        bus.cdb_stall = 1'b1;
        set_req(2, 1, 4'd9, 32'h99, 3'd5);
        set_req(0, 1, 4'd10, 32'hAA, 3'd7);
        for (int n = 0; n < 3; n++) begin
            tick();
            expect_idle("stall");
        end
        bus.cdb_stall = 1'b0;
        tick();
        expect_out("stall_rel", 1, 4'd9, 32'h99, 2'd2, 3'b100, 3'd5);
        tick();
        expect_out("stall_next", 1, 4'd10, 32'hAA, 2'd0, 3'b001, 3'd7);
        set_req(2, 0, 0, 0, 0);
        tick();
        expect_idle("stall_drain");
        set_req(0, 0, 0, 0, 0);

        // flush with units 0 and 2 eligible; pointer was 0
        set_req(0, 1, 4'd11, 32'hBB, 3'd1);
        set_req(2, 1, 4'd12, 32'hCC, 3'd2);
        bus.flush = 1'b1;
        tick();
        expect_idle("flush");
        bus.flush = 1'b0;
        tick();
        expect_out("flush_u0", 1, 4'd11, 32'hBB, 2'd0, 3'b001, 3'd1);
        tick();
        expect_out("flush_u2", 1, 4'd12, 32'hCC, 2'd2, 3'b100, 3'd2);
        set_req(0, 0, 0, 0, 0);
        tick();
        expect_idle("flush_drain");
        set_req(2, 0, 0, 0, 0);

        // reset mid-burst
        set_req(0, 1, 4'd3, 32'h30, 3'd3);
        set_req(1, 1, 4'd4, 32'h40, 3'd4);
        tick();
        expect_out("burst_u0", 1, 4'd3, 32'h30, 2'd0, 3'b001, 3'd3);
        rst = 1'b1;
        tick();
        expect_idle("mid_reset");
        rst = 1'b0;
        tick();
        expect_out("post_rst_u0", 1, 4'd3, 32'h30, 2'd0, 3'b001, 3'd3);
        tick();
        expect_out("post_rst_u1", 1, 4'd4, 32'h40, 2'd1, 3'b010, 3'd4);
        set_req(0, 0, 0, 0, 0);
        tick();
        expect_idle("post_rst_drain");
        set_req(1, 0, 0, 0, 0);

        // tag 0 is never granted
        set_req(1, 1, 4'd0, 32'hDEAD, 3'd6);
        tick();
        expect_idle("tag0_a");
        tick();
        expect_idle("tag0_b");
        set_req(2, 1, 4'd5, 32'h55, 3'd1);
        tick();
        expect_out("tag0_skip", 1, 4'd5, 32'h55, 2'd2, 3'b100, 3'd1);
        set_req(1, 0, 0, 0, 0);
        tick();
        expect_idle("tag0_drain");
        set_req(2, 0, 0, 0, 0);
        tick();
        expect_cnt("tag0_flagged", tag0_seen, 3);
        expect_cnt("tag0_bcast", bad_bcast, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
